// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the saturating-counter branch predictors:
// mode encodings and counter constants derived from counter width.
package gshare_predictor_pkg;

   typedef enum logic {
      MODE_BIMODAL = 1'b0,
      MODE_GSHARE  = 1'b1
   } mode_e;

   // Weakly not-taken: the largest value whose MSB is still clear.
   function automatic int unsigned ctr_reset_val(input int unsigned width);
      return (32'd1 << (width - 1)) - 32'd1;
   endfunction

   function automatic int unsigned ctr_max_val(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational saturating up/down step for one prediction counter.
// Taken moves toward max, not-taken toward zero; the rails hold.
module sat_counter_update
   import gshare_predictor_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] value_o
);

   localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(ctr_max_val(WIDTH));

   always_comb begin
      value_o = value_i;
      if (dir_i) begin
         if (value_i != CTR_MAX) value_o = value_i + WIDTH'(1);
      end else begin
         if (value_i != '0) value_o = value_i - WIDTH'(1);
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal/gshare direction predictor: one-cycle registered lookup, independent
// same-cycle training, speculative global history repaired on mispredict.
module gshare_predictor
   import gshare_predictor_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned COUNTER_WIDTH = 2,
   parameter int unsigned HISTORY_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic                     pred_valid,
   input  logic [ADDRESS_WIDTH-1:0] pred_address,
   output logic                     pred_out_valid,
   output logic                     pred_taken,
   output logic [ADDRESS_WIDTH-1:0] pred_index,
   output logic [HISTORY_WIDTH-1:0] pred_history,
   input  logic                     upd_valid,
   input  logic [ADDRESS_WIDTH-1:0] upd_index,
   input  logic [HISTORY_WIDTH-1:0] upd_history,
   input  logic                     upd_result,
   input  logic                     upd_mispredict,
   output logic [HISTORY_WIDTH-1:0] ghr,
   output logic [15:0]              mispredict_count
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [COUNTER_WIDTH-1:0] CTR_RST = COUNTER_WIDTH'(ctr_reset_val(COUNTER_WIDTH));

   logic [COUNTER_WIDTH-1:0] ctr_q [DEPTH];
   logic [COUNTER_WIDTH-1:0] ctr_upd;
   logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d, ghr_shift, ghr_repair;
   logic [ADDRESS_WIDTH-1:0] lkp_idx;
   logic                     lkp_taken;
   logic                     repair;
   logic                     out_vld_q, taken_q;
   logic [ADDRESS_WIDTH-1:0] index_q;
   logic [HISTORY_WIDTH-1:0] hist_q;
   logic [15:0]              mis_cnt_q, mis_cnt_d;
   logic                     unused_hist_msb;

   assign lkp_idx   = (mode == MODE_GSHARE) ? (pred_address ^ ADDRESS_WIDTH'(ghr_q)) : pred_address;
   assign lkp_taken = ctr_q[lkp_idx][COUNTER_WIDTH-1];
   assign repair    = upd_valid && upd_mispredict;

   // The oldest resolved-history bit falls off the end during repair.
   assign unused_hist_msb = upd_history[HISTORY_WIDTH-1];

   generate
      if (HISTORY_WIDTH == 1) begin : g_hist1
         assign ghr_shift  = lkp_taken;
         assign ghr_repair = upd_result;
      end else begin : g_histn
         assign ghr_shift  = {ghr_q[HISTORY_WIDTH-2:0], lkp_taken};
         assign ghr_repair = {upd_history[HISTORY_WIDTH-2:0], upd_result};
      end
   endgenerate

   // Repair outranks the speculative shift of a lookup in the same cycle.
   always_comb begin
      ghr_d = ghr_q;
      if (pred_valid) ghr_d = ghr_shift;
      if (repair)     ghr_d = ghr_repair;
   end

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      if (repair && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
   end

   sat_counter_update #(.WIDTH(COUNTER_WIDTH)) u_sat (
      .value_i (ctr_q[upd_index]),
      .dir_i   (upd_result),
      .value_o (ctr_upd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
         ghr_q     <= '0;
         out_vld_q <= 1'b0;
         taken_q   <= 1'b0;
         index_q   <= '0;
         hist_q    <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (upd_valid) ctr_q[upd_index] <= ctr_upd;
         ghr_q     <= ghr_d;
         out_vld_q <= pred_valid;
         if (pred_valid) begin
            taken_q <= lkp_taken;
            index_q <= lkp_idx;
            hist_q  <= ghr_q;
         end
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign pred_out_valid   = out_vld_q;
   assign pred_taken       = taken_q;
   assign pred_index       = index_q;
   assign pred_history     = hist_q;
   assign ghr              = ghr_q;
   assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Table-driven bench for gshare_predictor with a scoreboard of expected lookups.
module tb_gshare_predictor;
   import gshare_predictor_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       pred_valid;
   logic [3:0] pred_address;
   logic       pred_out_valid;
   logic       pred_taken;
   logic [3:0] pred_index;
   logic [3:0] pred_history;
   logic       upd_valid;
   logic [3:0] upd_index;
   logic [3:0] upd_history;
   logic       upd_result;
   logic       upd_mispredict;
   logic [3:0] ghr;
   logic [15:0] mispredict_count;

   gshare_predictor #(.ADDRESS_WIDTH(4), .COUNTER_WIDTH(2), .HISTORY_WIDTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .mode             (mode),
      .pred_valid       (pred_valid),
      .pred_address     (pred_address),
      .pred_out_valid   (pred_out_valid),
      .pred_taken       (pred_taken),
      .pred_index       (pred_index),
      .pred_history     (pred_history),
      .upd_valid        (upd_valid),
      .upd_index        (upd_index),
      .upd_history      (upd_history),
      .upd_result       (upd_result),
      .upd_mispredict   (upd_mispredict),
      .ghr              (ghr),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       taken;
      logic [3:0] idx;
      logic [3:0] hist;
   } exp_t;

   typedef struct packed {
      logic       pv;
      logic       md;
      logic [3:0] addr;
      logic       uv;
      logic [3:0] uidx;
      logic [3:0] uhist;
      logic       ures;
      logic       umis;
      logic       ex_taken;
      logic [3:0] ex_idx;
      logic [3:0] ex_hist;
      logic [3:0] ex_ghr;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[20];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic pv, input logic md, input logic [3:0] addr,
                        input logic uv, input logic [3:0] uidx, input logic [3:0] uhist,
                        input logic ures, input logic umis);
      pred_valid     = pv;
      mode           = md;
      pred_address   = addr;
      upd_valid      = uv;
      upd_index      = uidx;
      upd_history    = uhist;
      upd_result     = ures;
      upd_mispredict = umis;
   endtask

   task automatic idle();
      drive(1'b0, mode, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare the registered lookup outputs against the oldest scoreboard entry.
   task automatic post_check(input logic exp_vld);
      exp_t e;
      check("pred_out_valid", 32'(pred_out_valid), 32'(exp_vld));
      if (exp_vld) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got lookup output, expected no pending entry");
         end else begin
            e = sb_q.pop_front();
            check("pred_taken",   32'(pred_taken),   32'(e.taken));
            check("pred_index",   32'(pred_index),   32'(e.idx));
            check("pred_history", 32'(pred_history), 32'(e.hist));
         end
      end
   endtask

   task automatic lookup(input logic md, input logic [3:0] addr, input exp_t e);
      drive(1'b1, md, addr, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      sb_q.push_back(e);
      step();
      post_check(1'b1);
   endtask

   task automatic train(input logic [3:0] idx, input logic res);
      drive(1'b0, MODE_BIMODAL, 4'd0, 1'b1, idx, 4'd0, res, 1'b0);
      step();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      //   pv md addr uv uidx uhist ures umis | taken idx hist ghr_after
      vecs[0]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0000};
      vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0000};
      vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0000};
      vecs[3]  = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5, 4'b0000, 4'b0001};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001};
      vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001};
      vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001};
      vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001};
      vecs[8]  = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5, 4'b0001, 4'b0010};
      vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0010};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0010};
      vecs[11] = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5, 4'b0010, 4'b0101};
      vecs[12] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'b0101, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'b1010};
      vecs[13] = '{1'b1, 1'b1, 4'b0011, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1010, 4'b0100};
      vecs[14] = '{1'b1, 1'b0, 4'h7, 1'b1, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7, 4'b0100, 4'b1000};
      vecs[15] = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h7, 4'b1000, 4'b0001};
      vecs[16] = '{1'b1, 1'b1, 4'h2, 1'b1, 4'h3, 4'b0011, 1'b1, 1'b1, 1'b0, 4'h3, 4'b0001, 4'b0111};
      vecs[17] = '{1'b1, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 4'b0111, 4'b1111};
      vecs[18] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b1111};
      vecs[19] = '{1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 4'b1111, 4'b1111};

      rst  = 1'b0;
      mode = MODE_BIMODAL;
      idle();
      step();
      step();
      check("rst_out_valid", 32'(pred_out_valid), 32'd0);
      check("rst_taken",     32'(pred_taken),     32'd0);
      check("rst_index",     32'(pred_index),     32'd0);
      check("rst_history",   32'(pred_history),   32'd0);
      check("rst_ghr",       32'(ghr),            32'd0);
      check("rst_mis_count", 32'(mispredict_count), 32'd0);
      rst = 1'b1;

      for (int a = 0; a < 16; a++) lookup(MODE_BIMODAL, 4'(a), '{1'b0, 4'(a), 4'd0});
      idle();
      step();
      post_check(1'b0);
      check("sweep_ghr",       32'(ghr),              32'd0);
      check("sweep_mis_count", 32'(mispredict_count), 32'd0);

      for (int v = 0; v < 20; v++) begin
         drive(vecs[v].pv, vecs[v].md, vecs[v].addr, vecs[v].uv, vecs[v].uidx,
               vecs[v].uhist, vecs[v].ures, vecs[v].umis);
         if (vecs[v].pv) sb_q.push_back('{vecs[v].ex_taken, vecs[v].ex_idx, vecs[v].ex_hist});
         step();
         post_check(vecs[v].pv);
         check($sformatf("vec%0d_ghr", v), 32'(ghr), 32'(vecs[v].ex_ghr));
      end
      check("table_mis_count", 32'(mispredict_count), 32'd2);

      // Reset in the middle of a lookup stream drops the in-flight lookup.
      lookup(MODE_BIMODAL, 4'h7, '{1'b1, 4'h7, 4'b1111});
      drive(1'b1, MODE_BIMODAL, 4'h7, 1'b1, 4'h7, 4'h0, 1'b1, 1'b1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      idle();
      check("mid_rst_out_valid", 32'(pred_out_valid),   32'd0);
      check("mid_rst_taken",     32'(pred_taken),       32'd0);
      check("mid_rst_index",     32'(pred_index),       32'd0);
      check("mid_rst_ghr",       32'(ghr),              32'd0);
      check("mid_rst_mis_count", 32'(mispredict_count), 32'd0);
      for (int a = 0; a < 16; a++) lookup(MODE_BIMODAL, 4'(a), '{1'b0, 4'(a), 4'd0});
      train(4'h0, 1'b1);
      lookup(MODE_BIMODAL, 4'h0, '{1'b1, 4'h0, 4'd0});
      check("post_rst_ghr", 32'(ghr), 32'b0001);

      for (int i = 0; i < 65534; i++) begin
         drive(1'b0, MODE_BIMODAL, 4'd0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
         step();
      end
      check("mis_count_fffe", 32'(mispredict_count), 32'hFFFE);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, MODE_BIMODAL, 4'd0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
         step();
      end
      idle();
      check("mis_count_sat", 32'(mispredict_count), 32'hFFFF);
      post_check(1'b0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
